// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_sequencer_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;

  // Source that wins the next-pc selection, highest priority first.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_HOLD,
    SRC_RET,
    SRC_JUMP,
    SRC_BR,
    SRC_SEQ
  } src_t;

  // Mask of the address bits that must be zero for an instruction of the given size.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return 64'(instr_bytes - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect inputs and pc/status outputs between decode/execute and the pc sequencer.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            branch;
  logic            branch_cond;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic            link;
  logic [XLEN-1:0] jump_target;
  logic            ret;
  logic            trap;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] epc;
  logic            ras_empty;
  logic            ras_overflow;
  logic            ras_underflow;
  logic            misaligned;

  modport master (
    output stall, branch, branch_cond, branch_target, jump, link, jump_target, ret, trap,
    input  pc, pc_plus, epc, ras_empty, ras_overflow, ras_underflow, misaligned
  );

  modport slave (
    input  stall, branch, branch_cond, branch_target, jump, link, jump_target, ret, trap,
    output pc, pc_plus, epc, ras_empty, ras_overflow, ras_underflow, misaligned
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry.
module return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned XLEN      = DEFAULT_XLEN,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow
);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(RAS_DEPTH));

  // Pointer, occupancy and sticky overflow; wrapping ptr lands on the oldest slot when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (full) overflow <= 1'b1;
      else      count    <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage, written at the slot above the current top.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[ptr + 1'b1] <= data_in;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects and a return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  localparam logic [XLEN-1:0] INC      = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(align_mask(INSTR_BYTES));

  src_t            src;
  logic [XLEN-1:0] pc_q, epc_q, pc_plus, pc_next, epc_next, ras_top;
  logic            underflow_q, misaligned_q, underflow_next, misaligned_next;
  logic            push, pop, ras_empty, ras_overflow, ras_full_unused;

  assign pc_plus = pc_q + INC;

  return_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_plus),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full_unused),
    .overflow (ras_overflow)
  );

  // Pick the single redirect source that acts this cycle.
  always_comb begin
    src = SRC_SEQ;
    if      (bus.trap)                      src = SRC_TRAP;
    else if (bus.stall)                     src = SRC_HOLD;
    else if (bus.ret)                       src = SRC_RET;
    else if (bus.jump)                      src = SRC_JUMP;
    else if (bus.branch && bus.branch_cond) src = SRC_BR;
  end

  // Next pc/epc, stack control and pulse flags for the selected source only.
  always_comb begin
    pc_next         = pc_plus;
    epc_next        = epc_q;
    push            = 1'b0;
    pop             = 1'b0;
    underflow_next  = 1'b0;
    misaligned_next = 1'b0;
    case (src)
      SRC_TRAP: begin
        pc_next  = TRAP_VECTOR;
        epc_next = pc_q;
      end
      SRC_HOLD: pc_next = pc_q;
      SRC_RET: begin
        if (!ras_empty) begin
          pc_next = ras_top;
          pop     = 1'b1;
        end else begin
          underflow_next = 1'b1;
        end
      end
      SRC_JUMP: begin
        pc_next         = bus.jump_target & ~LOW_MASK;
        push            = bus.link;
        misaligned_next = |(bus.jump_target & LOW_MASK);
      end
      SRC_BR: begin
        pc_next         = bus.branch_target & ~LOW_MASK;
        misaligned_next = |(bus.branch_target & LOW_MASK);
      end
      default: ;
    endcase
  end

  // Architectural pc/epc and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      underflow_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_next;
      epc_q        <= epc_next;
      underflow_q  <= underflow_next;
      misaligned_q <= misaligned_next;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.epc           = epc_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_overflow  = ras_overflow;
  assign bus.ras_underflow = underflow_q;
  assign bus.misaligned    = misaligned_q;

endmodule
